// File: rtl/mcm_lane_array.sv
// Masked GF(2^8) lane-array multiplier: PAR lanes per cycle, two-stage
// pipeline (share cross products, then masked compression into out shares).
module mcm_lane_array #(
  parameter int LANES = 16,
  parameter int D     = 1,
  parameter int PAR   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        drdy_i,
  input  logic [LANES*(D+1)*8-1:0]    p1,
  input  logic [LANES*(D+1)*8-1:0]    p2,
  input  logic [1:0]                  p_det,
  input  logic [PAR*(D*(D+1)/2)*8-1:0] random_vect,
  input  logic                        rnd_vld,
  output logic [LANES*(D+1)*8-1:0]    out,
  output logic                        drdy_o,
  output logic                        busy
);

  localparam int S    = D + 1;
  localparam int R    = D * (D + 1) / 2;
  localparam int NG   = LANES / PAR;
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int W    = LANES * S * 8;
  localparam int GRPW = PAR * S * 8;
  localparam int PW   = PAR * S * S * 8;
  localparam int RW   = PAR * R * 8;
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

  if (LANES % PAR != 0) begin : g_par_check
    $error("mcm_lane_array: LANES must be a multiple of PAR");
  end

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FLUSH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   g;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [7:0]      poly_q;
  logic [7:0]      poly_sel;
  logic [PW-1:0]   s1_prod;
  logic [RW-1:0]   s1_r;
  logic [GW-1:0]   s1_g;
  logic            s1_vld;
  logic [W-1:0]    res;
  logic [W-1:0]    res_next;
  logic [GRPW-1:0] grp_a;
  logic [GRPW-1:0] grp_b;
  logic [PW-1:0]   prod_c;
  logic [GRPW-1:0] comp_c;

  // Polynomial stored without its implicit x^8 term.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] poly);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ poly) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic int pair_idx(input int i, input int j);
    return i * S - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  always_comb begin
    case (p_det)
      2'd0:    poly_sel = 8'h1B;
      2'd1:    poly_sel = 8'h1D;
      2'd2:    poly_sel = 8'h2B;
      default: poly_sel = 8'h4D;
    endcase
  end

  assign grp_a = a_q[g*GRPW +: GRPW];
  assign grp_b = b_q[g*GRPW +: GRPW];
  assign busy  = (state != IDLE);

  always_comb begin
    prod_c = '0;
    for (int p = 0; p < PAR; p++) begin
      for (int i = 0; i < S; i++) begin
        for (int j = 0; j < S; j++) begin
          prod_c[((p*S+i)*S+j)*8 +: 8] = gf_mul(grp_a[(p*S+i)*8 +: 8],
                                                grp_b[(p*S+j)*8 +: 8], poly_q);
        end
      end
    end
  end

  // Each pair mask r{i,j} lands in exactly two output shares, so it cancels
  // in the recombined product.
  always_comb begin : compress
    logic [7:0] acc;
    comp_c = '0;
    for (int p = 0; p < PAR; p++) begin
      for (int i = 0; i < S; i++) begin
        acc = s1_prod[((p*S+i)*S+i)*8 +: 8];
        for (int j = 0; j < S; j++) begin
          if (j != i) begin
            acc = acc ^ s1_prod[((p*S+i)*S+j)*8 +: 8]
                      ^ s1_r[(p*R + pair_idx((i < j) ? i : j, (i < j) ? j : i))*8 +: 8];
          end
        end
        comp_c[(p*S+i)*8 +: 8] = acc;
      end
    end
  end

  always_comb begin
    res_next = res;
    res_next[s1_g*GRPW +: GRPW] = comp_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drdy_i) state_nxt = MUL;
      MUL:     if (rnd_vld && (g == G_LAST)) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results accumulate in res; out only changes at FLUSH so it always shows
  // the last completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      poly_q  <= '0;
      s1_prod <= '0;
      s1_r    <= '0;
      s1_g    <= '0;
      s1_vld  <= 1'b0;
      res     <= '0;
      out     <= '0;
      drdy_o  <= 1'b0;
    end else begin
      drdy_o <= 1'b0;
      case (state)
        IDLE: begin
          if (drdy_i) begin
            a_q    <= p1;
            b_q    <= p2;
            poly_q <= poly_sel;
            g      <= '0;
            s1_vld <= 1'b0;
          end
        end
        MUL: begin
          if (rnd_vld) begin
            s1_prod <= prod_c;
            s1_r    <= random_vect;
            s1_g    <= g;
            s1_vld  <= 1'b1;
            if (s1_vld) res <= res_next;
            g <= (g == G_LAST) ? '0 : g + 1'b1;
          end
        end
        FLUSH: begin
          res    <= res_next;
          out    <= res_next;
          s1_vld <= 1'b0;
          drdy_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcm_lane_array.sv
// Directed bench for mcm_lane_array (LANES=16, D=1, PAR=4): latency, stalls,
// polynomial select, masked shares, back-to-back and mid-operation reset.
module tb_mcm_lane_array;

  localparam int LANES = 16;
  localparam int PAR   = 4;
  localparam int W     = LANES * 2 * 8;
  localparam int RW    = PAR * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drdy_i = 1'b0;
  logic          rnd_vld = 1'b0;
  logic [W-1:0]  p1 = '0;
  logic [W-1:0]  p2 = '0;
  logic [1:0]    p_det = 2'd0;
  logic [RW-1:0] random_vect = '0;
  logic [W-1:0]  out;
  logic          drdy_o;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]    la0[LANES];
  logic [7:0]    la1[LANES];
  logic [7:0]    lb0[LANES];
  logic [7:0]    lb1[LANES];
  logic [RW-1:0] rv_base = '0;
  bit            rv_vary = 1'b0;

  mcm_lane_array #(.LANES(LANES), .D(1), .PAR(PAR)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .p1(p1), .p2(p2), .p_det(p_det),
    .random_vect(random_vect), .rnd_vld(rnd_vld), .out(out),
    .drdy_o(drdy_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Carry-less product followed by long division by the full 9-bit polynomial.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] pd);
    logic [14:0] c;
    logic [8:0]  p9;
    case (pd)
      2'd0:    p9 = 9'h11B;
      2'd1:    p9 = 9'h11D;
      2'd2:    p9 = 9'h12B;
      default: p9 = 9'h14D;
    endcase
    c = '0;
    for (int n = 0; n < 8; n++) if (b[n]) c = c ^ (15'(a) << n);
    for (int n = 14; n >= 8; n--) if (c[n]) c = c ^ (15'(p9) << (n - 8));
    return c[7:0];
  endfunction

  function automatic logic [7:0] exp_share(input int l, input int i, input logic [1:0] pd);
    logic [7:0] r;
    r = rv_base[8*(l%PAR) +: 8];
    if (rv_vary) r = r ^ 8'(l/PAR + 1);
    if (i == 0) return ref_mul(la0[l], lb0[l], pd) ^ ref_mul(la0[l], lb1[l], pd) ^ r;
    else        return ref_mul(la1[l], lb1[l], pd) ^ ref_mul(la1[l], lb0[l], pd) ^ r;
  endfunction

  task automatic set_all(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] b0, input logic [7:0] b1);
    for (int l = 0; l < LANES; l++) begin
      la0[l] = a0; la1[l] = a1; lb0[l] = b0; lb1[l] = b1;
    end
  endtask

  // Drives the start cycle, then scrambles the inputs to prove they were latched.
  task automatic start_op(input logic [1:0] pd);
    for (int l = 0; l < LANES; l++) begin
      p1[16*l +: 8] = la0[l]; p1[16*l+8 +: 8] = la1[l];
      p2[16*l +: 8] = lb0[l]; p2[16*l+8 +: 8] = lb1[l];
    end
    p_det  = pd;
    drdy_i = 1'b1;
    @(posedge clk); #1;
    drdy_i = 1'b0;
    p1     = ~p1;
    p2     = ~p2;
    p_det  = ~pd;
  endtask

  task automatic wait_done(input int stall_start, input int stall_len, input int poke,
                           output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      rnd_vld     = !(n >= stall_start && n < stall_start + stall_len);
      random_vect = rv_vary ? (rv_base ^ {PAR{8'(n)}}) : rv_base;
      drdy_i      = (n == poke);
      @(posedge clk); #1;
      if (drdy_o) begin
        lat = n;
        break;
      end
    end
    drdy_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out !== '0) begin bad++; $display("[TB] FAIL reset_out got=%h exp=0", out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (drdy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_drdy got=%b exp=0", drdy_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    set_all(8'h57, 8'h00, 8'h83, 8'h00);
    rv_base = '0; rv_vary = 1'b0;
    start_op(2'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy got=%b exp=1", busy); end
    wait_done(0, 0, 0, lat);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=5", lat); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_fall got=%b exp=0", busy); end
    for (int l = 0; l < LANES; l++) begin
      total++;
      if (out[16*l +: 16] !== 16'h00C1) begin
        bad++; $display("[TB] FAIL basic_lane%0d got=%h exp=00c1", l, out[16*l +: 16]);
      end
    end
    @(posedge clk); #1;
    total++; if (drdy_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse got=%b exp=0", drdy_o); end
    total++; if (out[15:0] !== 16'h00C1) begin bad++; $display("[TB] FAIL basic_hold got=%h exp=00c1", out[15:0]); end
  endtask

  task automatic test_poly();
    int lat;
    logic [7:0] exp_v[4];
    exp_v[0] = 8'h1B; exp_v[1] = 8'h1D; exp_v[2] = 8'h2B; exp_v[3] = 8'h4D;
    set_all(8'h02, 8'h00, 8'h80, 8'h00);
    rv_base = '0; rv_vary = 1'b0;
    for (int pd = 0; pd < 4; pd++) begin
      start_op(2'(pd));
      wait_done(0, 0, 0, lat);
      total++; if (lat !== 5) begin bad++; $display("[TB] FAIL poly%0d_latency got=%0d exp=5", pd, lat); end
      for (int l = 0; l < LANES; l += 5) begin
        total++;
        if ((out[16*l +: 8] ^ out[16*l+8 +: 8]) !== exp_v[pd]) begin
          bad++; $display("[TB] FAIL poly%0d_lane%0d got=%h exp=%h", pd, l,
                          out[16*l +: 8] ^ out[16*l+8 +: 8], exp_v[pd]);
        end
      end
    end
  endtask

  task automatic test_masked();
    int lat;
    set_all(8'h57 ^ 8'hA5, 8'hA5, 8'h83 ^ 8'h3C, 8'h3C);
    rv_base = 32'h5A5A5A5A; rv_vary = 1'b0;
    start_op(2'd0);
    wait_done(0, 0, 0, lat);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL masked_latency got=%0d exp=5", lat); end
    for (int l = 0; l < LANES; l++) begin
      total++;
      if ((out[16*l +: 8] ^ out[16*l+8 +: 8]) !== 8'hC1) begin
        bad++; $display("[TB] FAIL masked_xor%0d got=%h exp=c1", l, out[16*l +: 8] ^ out[16*l+8 +: 8]);
      end
      total++;
      if (out[16*l +: 16] !== {exp_share(l, 1, 2'd0), exp_share(l, 0, 2'd0)}) begin
        bad++; $display("[TB] FAIL masked_share%0d got=%h exp=%h", l, out[16*l +: 16],
                        {exp_share(l, 1, 2'd0), exp_share(l, 0, 2'd0)});
      end
    end
  endtask

  task automatic test_lanes();
    int lat;
    for (int l = 0; l < LANES; l++) begin
      la0[l] = 8'(l*17 + 1); la1[l] = 8'(l*29 + 3);
      lb0[l] = 8'(8'hF0 - l*7); lb1[l] = 8'(l*11);
    end
    rv_base = 32'h11223344; rv_vary = 1'b1;
    start_op(2'd2);
    wait_done(0, 0, 0, lat);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL lanes_latency got=%0d exp=5", lat); end
    for (int l = 0; l < LANES; l++) begin
      total++;
      if (out[16*l +: 16] !== {exp_share(l, 1, 2'd2), exp_share(l, 0, 2'd2)}) begin
        bad++; $display("[TB] FAIL lanes_share%0d got=%h exp=%h", l, out[16*l +: 16],
                        {exp_share(l, 1, 2'd2), exp_share(l, 0, 2'd2)});
      end
      total++;
      if ((out[16*l +: 8] ^ out[16*l+8 +: 8]) !== ref_mul(la0[l] ^ la1[l], lb0[l] ^ lb1[l], 2'd2)) begin
        bad++; $display("[TB] FAIL lanes_xor%0d got=%h exp=%h", l, out[16*l +: 8] ^ out[16*l+8 +: 8],
                        ref_mul(la0[l] ^ la1[l], lb0[l] ^ lb1[l], 2'd2));
      end
    end
    rv_vary = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    set_all(8'h57, 8'h00, 8'h83, 8'h00);
    rv_base = '0; rv_vary = 1'b0;
    start_op(2'd0);
    wait_done(2, 3, 3, lat);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL stall_latency got=%0d exp=8", lat); end
    for (int l = 0; l < LANES; l += 3) begin
      total++;
      if (out[16*l +: 16] !== 16'h00C1) begin
        bad++; $display("[TB] FAIL stall_lane%0d got=%h exp=00c1", l, out[16*l +: 16]);
      end
    end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stall_poke_ignored got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_all(8'h57, 8'h00, 8'h83, 8'h00);
    rv_base = '0; rv_vary = 1'b0;
    start_op(2'd0);
    wait_done(0, 0, 0, lat);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL b2b_first_latency got=%0d exp=5", lat); end
    set_all(8'h02, 8'h00, 8'h80, 8'h00);
    start_op(2'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart_busy got=%b exp=1", busy); end
    total++; if (drdy_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_pulse got=%b exp=0", drdy_o); end
    total++; if (out[15:0] !== 16'h00C1) begin bad++; $display("[TB] FAIL b2b_hold got=%h exp=00c1", out[15:0]); end
    wait_done(0, 0, 0, lat);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL b2b_second_latency got=%0d exp=5", lat); end
    total++; if ((out[8*30 +: 8] ^ out[8*31 +: 8]) !== 8'h1D) begin
      bad++; $display("[TB] FAIL b2b_result got=%h exp=1d", out[8*30 +: 8] ^ out[8*31 +: 8]);
    end
  endtask

  task automatic test_reset_mid();
    int  lat;
    bit  seen;
    set_all(8'h57, 8'h00, 8'h83, 8'h00);
    rv_base = '0; rv_vary = 1'b0;
    start_op(2'd0);
    rnd_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (out !== '0) begin bad++; $display("[TB] FAIL rstmid_out got=%h exp=0", out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (drdy_o) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_drdy got=%b exp=0", seen); end
    start_op(2'd0);
    wait_done(0, 0, 0, lat);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL rstmid_latency got=%0d exp=5", lat); end
    total++; if (out[16*9 +: 16] !== 16'h00C1) begin
      bad++; $display("[TB] FAIL rstmid_result got=%h exp=00c1", out[16*9 +: 16]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_poly();
    test_masked();
    test_lanes();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
